// File: rtl/gps_accum_reader_pkg.sv
// gps_accum_reader_pkg
//   Shared definitions for the accumulation snapshot reader: baseband word
//   offsets, FSM state encodings and the frame header layout.
package gps_accum_reader_pkg;

    // Word offsets inside the baseband register slave (byte addr = 4*offset)
    localparam logic [7:0] OFS_CH0_BASE  = 8'h04;
    localparam logic [7:0] OFS_STATUS    = 8'hE0;
    localparam logic [7:0] OFS_NEWDATA   = 8'hE1;
    localparam logic [7:0] OFS_ACCUM_CNT = 8'hE3;

    // STATUS bit that says a dump is available; NEW_DATA bit for channel 0
    localparam int STATUS_DUMP_BIT = 1;
    localparam int NEWDATA_CH0_BIT = 0;

    // Header word layout: {28'h0, new_data[0], 1'b0, status[1:0]}
    localparam int HDR_STAT_LSB = 0;
    localparam int HDR_NEW_BIT  = 3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_STAT,
        ST_RD_TS,
        ST_RD_NEW,
        ST_RD_CH,
        ST_STREAM
    } state_t;

    typedef enum logic {
        RD_IDLE,
        RD_ISSUE
    } rd_state_t;

    function automatic logic [31:0] hdr_word(input logic [1:0] status, input logic new_data);
        logic [31:0] w;
        w = 32'h0;
        w[HDR_STAT_LSB +: 2] = status;
        w[HDR_NEW_BIT]       = new_data;
        return w;
    endfunction

endpackage

// File: rtl/gps_accum_reader_wb_single_read.sv
// wb_single_read
//   One Wishbone classic read per req pulse, with an ack timeout.
//   Bus outputs are registered. cyc/stb drop on the edge that sees ack (or
//   timeout), and req is only honoured from RD_IDLE, so a requester that
//   registers its next req off 'done' always leaves one idle bus cycle
//   between strobes (the slave toggles ack).
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   req, word_offset  start a read of ADDR_BASE + 4*word_offset
//   done              ack seen this cycle; data is valid alongside it
//   data              read data (wb_dat_i, meaningful with done)
//   timeout_err       TIMEOUT cycles elapsed without ack; read abandoned
//   wb_*              Wishbone initiator signals
module wb_single_read
    import gps_accum_reader_pkg::*;
#(
    parameter logic [31:0] ADDR_BASE = 32'h0000_0000,
    parameter int          TIMEOUT   = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic [7:0]  word_offset,
    output logic        done,
    output logic [31:0] data,
    output logic        timeout_err,
    output logic [31:0] wb_adr_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic [3:0]  wb_sel_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack_i
);

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    rd_state_t  state;
    logic [7:0] wait_cnt;

    // An ack on the same edge the counter expires wins over the timeout.
    assign done        = (state == RD_ISSUE) && wb_ack_i;
    assign timeout_err = (state == RD_ISSUE) && !wb_ack_i && (wait_cnt == TO_LAST);
    assign data        = wb_dat_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= RD_IDLE;
            wait_cnt <= 8'd0;
            wb_adr_o <= 32'h0;
            wb_cyc_o <= 1'b0;
            wb_stb_o <= 1'b0;
            wb_sel_o <= 4'h0;
        end else begin
            case (state)
                RD_IDLE: begin
                    // A late ack while idle lands here and is ignored.
                    if (req) begin
                        state    <= RD_ISSUE;
                        wait_cnt <= 8'd0;
                        wb_adr_o <= ADDR_BASE + {22'h0, word_offset, 2'b00};
                        wb_cyc_o <= 1'b1;
                        wb_stb_o <= 1'b1;
                        wb_sel_o <= 4'hF;
                    end
                end
                RD_ISSUE: begin
                    if (done || timeout_err) begin
                        state    <= RD_IDLE;
                        wb_cyc_o <= 1'b0;
                        wb_stb_o <= 1'b0;
                        wb_sel_o <= 4'h0;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                default: state <= RD_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/gps_accum_reader.sv
// gps_accum_reader
//   Wishbone initiator that drains a baseband accumulation snapshot on a
//   rising edge of start: STATUS, optionally the accum count, NEW_DATA and,
//   when channel 0 dumped, CH_REGS channel words. The frame is buffered and
//   streamed out over a valid/ready port.
//   Optional build macro GPS_ACCUM_READER_TIMESTAMP_EN inserts an accum_count
//   read (offset 8'hE3) after STATUS and places {8'h0, count} as word 1.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   start                         trigger level (rising edge = frame request)
//   wb_adr_o..wb_ack_i            Wishbone initiator (read only)
//   out_data/out_valid/out_ready  frame word stream, out_last on final word
//   busy                          FSM not idle
//   err                           sticky bus timeout, cleared by next frame
//   missed_cnt                    saturating count of dropped triggers
module gps_accum_reader
    import gps_accum_reader_pkg::*;
#(
    parameter logic [31:0] ADDR_BASE = 32'h0000_0000,
    parameter int          CH_REGS   = 10,
    parameter int          TIMEOUT   = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic [31:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    input  logic [31:0] wb_dat_i,
    output logic [3:0]  wb_sel_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic        wb_we_o,
    input  logic        wb_ack_i,
    output logic [31:0] out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_last,
    output logic        busy,
    output logic        err,
    output logic [7:0]  missed_cnt
);

`ifdef GPS_ACCUM_READER_TIMESTAMP_EN
    localparam int HDR_WORDS = 2;
`else
    localparam int HDR_WORDS = 1;
`endif
    localparam int FRAME_MAX = HDR_WORDS + CH_REGS;
    localparam int IW        = $clog2(FRAME_MAX + 1);

    typedef logic [IW-1:0] idx_t;
    localparam idx_t IDX_ONE   = idx_t'(1);
    localparam idx_t LEN_SHORT = idx_t'(HDR_WORDS);
    localparam idx_t LEN_FULL  = idx_t'(FRAME_MAX);
    localparam idx_t CH_LAST   = idx_t'(CH_REGS - 1);

    state_t      state;
    logic        start_q;
    logic        start_edge;
    logic        pending;
    logic [1:0]  status_q;
    idx_t        ch_idx;
    idx_t        out_idx;
    idx_t        frame_len;
    idx_t        next_ch;
    idx_t        next_out;
    logic        rd_req;
    logic [7:0]  rd_ofs;
    logic        rd_done;
    logic        rd_to;
    logic [31:0] rd_data;

    logic [31:0] frame_buf [FRAME_MAX];
    logic        buf_we;
    idx_t        buf_wa;
    logic [31:0] buf_wd;

    assign start_edge = start & ~start_q;
    assign next_ch    = ch_idx + IDX_ONE;
    assign next_out   = out_idx + IDX_ONE;
    assign busy       = (state != ST_IDLE);
    assign wb_dat_o   = 32'h0;
    assign wb_we_o    = 1'b0;

    wb_single_read #(
        .ADDR_BASE (ADDR_BASE),
        .TIMEOUT   (TIMEOUT)
    ) u_rd (
        .clk         (clk),
        .rst         (rst),
        .req         (rd_req),
        .word_offset (rd_ofs),
        .done        (rd_done),
        .data        (rd_data),
        .timeout_err (rd_to),
        .wb_adr_o    (wb_adr_o),
        .wb_cyc_o    (wb_cyc_o),
        .wb_stb_o    (wb_stb_o),
        .wb_sel_o    (wb_sel_o),
        .wb_dat_i    (wb_dat_i),
        .wb_ack_i    (wb_ack_i)
    );

    // Where each completed read lands in the frame buffer.
    always_comb begin
        buf_we = 1'b0;
        buf_wa = '0;
        buf_wd = rd_data;
        if (rd_done) begin
            case (state)
                ST_RD_NEW: begin
                    buf_we = 1'b1;
                    buf_wd = hdr_word(status_q, rd_data[NEWDATA_CH0_BIT]);
                end
`ifdef GPS_ACCUM_READER_TIMESTAMP_EN
                ST_RD_TS: begin
                    buf_we = 1'b1;
                    buf_wa = IDX_ONE;
                    buf_wd = {8'h0, rd_data[23:0]};
                end
`endif
                ST_RD_CH: begin
                    buf_we = 1'b1;
                    buf_wa = ch_idx + LEN_SHORT;
                end
                default: buf_we = 1'b0;
            endcase
        end
    end

    // Frame storage carries no reset; contents are only read after a full fill.
    always_ff @(posedge clk) begin
        if (buf_we) frame_buf[buf_wa] <= buf_wd;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            start_q    <= start;   // a level already high at reset is not an edge
            pending    <= 1'b0;
            missed_cnt <= 8'h00;
            err        <= 1'b0;
            status_q   <= 2'b00;
            ch_idx     <= '0;
            out_idx    <= '0;
            frame_len  <= '0;
            rd_req     <= 1'b0;
            rd_ofs     <= 8'h00;
            out_valid  <= 1'b0;
            out_data   <= 32'h0;
            out_last   <= 1'b0;
        end else begin
            start_q <= start;
            rd_req  <= 1'b0;

            // One request can wait behind the running frame; extras are counted.
            if (state != ST_IDLE && start_edge) begin
                if (pending) begin
                    if (missed_cnt != 8'hFF) missed_cnt <= missed_cnt + 8'd1;
                end else begin
                    pending <= 1'b1;
                end
            end

            if (rd_to) begin
                err   <= 1'b1;
                state <= ST_IDLE;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (start_edge || pending) begin
                            if (start_edge && pending && missed_cnt != 8'hFF)
                                missed_cnt <= missed_cnt + 8'd1;
                            pending <= 1'b0;
                            err     <= 1'b0;
                            state   <= ST_RD_STAT;
                            rd_req  <= 1'b1;
                            rd_ofs  <= OFS_STATUS;
                        end
                    end
                    ST_RD_STAT: begin
                        if (rd_done) begin
                            status_q <= rd_data[1:0];
                            if (!rd_data[STATUS_DUMP_BIT]) begin
                                state <= ST_IDLE;    // spurious trigger
                            end else begin
                                rd_req <= 1'b1;
`ifdef GPS_ACCUM_READER_TIMESTAMP_EN
                                state  <= ST_RD_TS;
                                rd_ofs <= OFS_ACCUM_CNT;
`else
                                state  <= ST_RD_NEW;
                                rd_ofs <= OFS_NEWDATA;
`endif
                            end
                        end
                    end
                    ST_RD_TS: begin
                        if (rd_done) begin
                            state  <= ST_RD_NEW;
                            rd_req <= 1'b1;
                            rd_ofs <= OFS_NEWDATA;
                        end
                    end
                    ST_RD_NEW: begin
                        if (rd_done) begin
                            out_idx <= '0;
                            if (rd_data[NEWDATA_CH0_BIT]) begin
                                state     <= ST_RD_CH;
                                ch_idx    <= '0;
                                frame_len <= LEN_FULL;
                                rd_req    <= 1'b1;
                                rd_ofs    <= OFS_CH0_BASE;
                            end else begin
                                state     <= ST_STREAM;
                                frame_len <= LEN_SHORT;
                            end
                        end
                    end
                    ST_RD_CH: begin
                        if (rd_done) begin
                            if (ch_idx == CH_LAST) begin
                                state <= ST_STREAM;
                            end else begin
                                ch_idx <= next_ch;
                                rd_req <= 1'b1;
                                rd_ofs <= OFS_CH0_BASE + 8'(next_ch);
                            end
                        end
                    end
                    ST_STREAM: begin
                        // out_idx always names the word currently presented.
                        if (!out_valid) begin
                            out_valid <= 1'b1;
                            out_data  <= frame_buf[out_idx];
                            out_last  <= (out_idx == frame_len - IDX_ONE);
                        end else if (out_ready) begin
                            if (out_last) begin
                                out_valid <= 1'b0;
                                out_last  <= 1'b0;
                                state     <= ST_IDLE;
                            end else begin
                                out_idx  <= next_out;
                                out_data <= frame_buf[next_out];
                                out_last <= (next_out == frame_len - IDX_ONE);
                            end
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule
